// File: rtl/axi_ad9963_tx_datasel.sv
// AD9963 transmit data selector: buffers DMA I/Q samples in a small FIFO and,
// on each interface strobe, emits one 24-bit {Q, I} word taken from the DMA
// FIFO, a constant pattern, a ramp or a PN15 sequence. Reports DMA underflow.
//
// Ports (all in the dac_clk domain):
//   dac_clk, dac_rst   clock, synchronous active-high reset
//   dac_data_sel       source select: 0 DMA, 1 constant, 2 ramp, 3 PN15
//   dac_pat_data       constant pattern {Q[11:0], I[11:0]}
//   dac_enable_i/q     lane enables; a disabled lane outputs zero
//   dma_valid/ready    DMA sample handshake into the FIFO
//   dma_data           {Q[15:0], I[15:0]}, MSB-justified (bits [15:4] used)
//   dac_valid          sample request strobe from the interface
//   dac_valid_out      output sample valid, one cycle after the strobe
//   dac_data           {Q[11:0], I[11:0]} to the interface
//   dac_dunf           one-cycle underflow pulse
//   dac_dunf_clr       clears dac_dunf_count
//   dac_dunf_count     saturating underflow count
module axi_ad9963_tx_datasel #(
  parameter int unsigned DATAPATH_DISABLE = 0,
  parameter int unsigned FIFO_ADDR_WIDTH  = 2
) (
  input  logic        dac_clk,
  input  logic        dac_rst,
  input  logic [1:0]  dac_data_sel,
  input  logic [23:0] dac_pat_data,
  input  logic        dac_enable_i,
  input  logic        dac_enable_q,
  input  logic        dma_valid,
  input  logic [31:0] dma_data,
  output logic        dma_ready,
  input  logic        dac_valid,
  output logic        dac_valid_out,
  output logic [23:0] dac_data,
  output logic        dac_dunf,
  input  logic        dac_dunf_clr,
  output logic [15:0] dac_dunf_count
);

  localparam int unsigned DEPTH     = 1 << FIFO_ADDR_WIDTH;
  localparam int unsigned CNT_W     = FIFO_ADDR_WIDTH + 1;
  localparam int unsigned LANE_W    = 12;
  localparam int unsigned LFSR_W    = 15;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF;

  localparam logic [1:0] SEL_DMA  = 2'd0;
  localparam logic [1:0] SEL_PAT  = 2'd1;
  localparam logic [1:0] SEL_RAMP = 2'd2;
  localparam logic [1:0] SEL_PN   = 2'd3;

  // FIFO storage and bookkeeping
  logic [31:0]                fifo_mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]           fifo_cnt;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic                       underflow;
  logic [31:0]                fifo_rd;
  logic                       unused_rd_bits;

  // Pattern generators
  logic [1:0]        sel_d;
  logic              sel_chg;
  logic [LANE_W-1:0] ramp;
  logic [LANE_W-1:0] ramp_cur;
  logic [LANE_W-1:0] ramp_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_cur;
  logic [LFSR_W-1:0] lfsr_nxt;

  // Source mux result
  logic [LANE_W-1:0] src_i;
  logic [LANE_W-1:0] src_q;
  logic [23:0]       data_nxt;

  assign fifo_full  = (fifo_cnt == CNT_W'(DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign dma_ready  = !fifo_full && !dac_rst;

  assign push      = dma_valid && dma_ready;
  assign pop       = dac_valid && (dac_data_sel == SEL_DMA) && !fifo_empty;
  // The pop decision sees the FIFO before any same-cycle push lands.
  assign underflow = dac_valid && (dac_data_sel == SEL_DMA) && fifo_empty;

  assign fifo_rd        = fifo_mem[rd_ptr];
  assign unused_rd_bits = ^{fifo_rd[19:16], fifo_rd[3:0]};

  // FIFO data array; contents are don't-care until written, so no reset.
  always_ff @(posedge dac_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= dma_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // A fresh selection of ramp/PN restarts that generator; the restart value
  // is visible to a strobe arriving in the same cycle as the change.
  assign sel_chg = (dac_data_sel != sel_d);

  always_comb begin
    ramp_cur = ramp;
    lfsr_cur = lfsr;
    if (sel_chg && (dac_data_sel == SEL_RAMP)) begin
      ramp_cur = '0;
    end
    if (sel_chg && (dac_data_sel == SEL_PN)) begin
      lfsr_cur = LFSR_SEED;
    end
  end

  // Generator advance: one step per strobe while selected.
  always_comb begin
    ramp_nxt = ramp_cur;
    lfsr_nxt = lfsr_cur;
    if (dac_valid && (dac_data_sel == SEL_RAMP)) begin
      ramp_nxt = ramp_cur + LANE_W'(1);
    end
    if (dac_valid && (dac_data_sel == SEL_PN)) begin
      // x^15 + x^14 + 1, feedback from taps 15 and 14 (bits 14 and 13)
      lfsr_nxt = {lfsr_cur[LFSR_W-2:0], lfsr_cur[14] ^ lfsr_cur[13]};
    end
  end

  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      sel_d <= SEL_DMA;
      ramp  <= '0;
      lfsr  <= LFSR_SEED;
    end else begin
      sel_d <= dac_data_sel;
      ramp  <= ramp_nxt;
      lfsr  <= lfsr_nxt;
    end
  end

  // Source mux followed by lane enable masking
  always_comb begin
    src_i = '0;
    src_q = '0;
    case (dac_data_sel)
      SEL_DMA: begin
        src_i = fifo_rd[15:4];
        src_q = fifo_rd[31:20];
      end
      SEL_PAT: begin
        src_i = dac_pat_data[11:0];
        src_q = dac_pat_data[23:12];
      end
      SEL_RAMP: begin
        if (DATAPATH_DISABLE == 0) begin
          src_i = ramp_cur;
          src_q = ~ramp_cur;
        end
      end
      default: begin
        if (DATAPATH_DISABLE == 0) begin
          src_i = lfsr_cur[11:0];
          src_q = lfsr_cur[14:3];
        end
      end
    endcase
    data_nxt = {dac_enable_q ? src_q : LANE_W'(0),
                dac_enable_i ? src_i : LANE_W'(0)};
  end

  // Output register stage; on underflow the previous sample is repeated.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      dac_valid_out <= 1'b0;
      dac_data      <= '0;
      dac_dunf      <= 1'b0;
    end else begin
      dac_valid_out <= dac_valid;
      dac_dunf      <= underflow;
      if (dac_valid && !underflow) begin
        dac_data <= data_nxt;
      end
    end
  end

  // Underflow counter; clear wins over a same-cycle increment.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      dac_dunf_count <= '0;
    end else if (dac_dunf_clr) begin
      dac_dunf_count <= '0;
    end else if (underflow && (dac_dunf_count != 16'hFFFF)) begin
      dac_dunf_count <= dac_dunf_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_axi_ad9963_tx_datasel.sv
// Self-checking bench for axi_ad9963_tx_datasel: a table of constant-pattern
// vectors plus directed sequences for FIFO, ramp, PN15, underflow and reset.
module tb_axi_ad9963_tx_datasel;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [23:0] pat;
  logic        en_i;
  logic        en_q;
  logic        dma_valid;
  logic [31:0] dma_data;
  logic        dma_ready;
  logic        strobe;
  logic        valid_out;
  logic [23:0] data;
  logic        dunf;
  logic        dunf_clr;
  logic [15:0] dunf_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_ad9963_tx_datasel #(
    .DATAPATH_DISABLE(0),
    .FIFO_ADDR_WIDTH (2)
  ) dut (
    .dac_clk       (clk),
    .dac_rst       (rst),
    .dac_data_sel  (sel),
    .dac_pat_data  (pat),
    .dac_enable_i  (en_i),
    .dac_enable_q  (en_q),
    .dma_valid     (dma_valid),
    .dma_data      (dma_data),
    .dma_ready     (dma_ready),
    .dac_valid     (strobe),
    .dac_valid_out (valid_out),
    .dac_data      (data),
    .dac_dunf      (dunf),
    .dac_dunf_clr  (dunf_clr),
    .dac_dunf_count(dunf_count)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [23:0] pat;
    logic        en_i;
    logic        en_q;
    logic        strobe;
    logic        exp_valid;
    logic [23:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] lfsr_step(input logic [14:0] l);
    return {l[13:0], l[14] ^ l[13]};
  endfunction

  initial begin
    logic [11:0] ei;
    logic [11:0] r;
    logic [14:0] l;
    logic [11:0] pn_i [3];
    logic [15:0] exp_cnt;

    pn_i[0] = 12'hFFF;
    pn_i[1] = 12'hFFE;
    pn_i[2] = 12'hFFC;

    //             sel   pat         ei    eq    stb   ev    expected
    vecs[0] = '{2'd1, 24'hABC123, 1'b1, 1'b1, 1'b1, 1'b1, 24'hABC123};
    vecs[1] = '{2'd1, 24'hABC123, 1'b1, 1'b1, 1'b1, 1'b1, 24'hABC123};
    vecs[2] = '{2'd1, 24'h123456, 1'b1, 1'b1, 1'b0, 1'b0, 24'hABC123};
    vecs[3] = '{2'd1, 24'h123456, 1'b1, 1'b1, 1'b1, 1'b1, 24'h123456};
    vecs[4] = '{2'd1, 24'hFFFFFF, 1'b0, 1'b1, 1'b1, 1'b1, 24'hFFF000};
    vecs[5] = '{2'd1, 24'hFFFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 24'h000FFF};
    vecs[6] = '{2'd1, 24'h555555, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};
    vecs[7] = '{2'd1, 24'h555555, 1'b1, 1'b1, 1'b1, 1'b1, 24'h555555};

    rst = 1'b1; sel = 2'd0; pat = '0; en_i = 1'b1; en_q = 1'b1;
    dma_valid = 1'b0; dma_data = '0; strobe = 1'b0; dunf_clr = 1'b0;
    tick();
    tick();
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_dunf", 32'(dunf), 32'h0);
    check("rst_count", 32'(dunf_count), 32'h0);
    check("rst_ready", 32'(dma_ready), 32'h0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(dma_ready), 32'h1);

    // Constant pattern and lane enables
    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel; pat = vecs[i].pat; en_i = vecs[i].en_i;
      en_q = vecs[i].en_q; strobe = vecs[i].strobe;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_dunf", i), 32'(dunf), 32'h0);
    end
    strobe = 1'b0; en_i = 1'b1; en_q = 1'b1;

    // DMA FIFO: fill to full, blocked push, drain, underflow
    sel = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ready_push%0d", k), 32'(dma_ready), 32'h1);
      dma_valid = 1'b1;
      dma_data = {16'hFED0, 16'(32'h1230 * k)};
      tick();
    end
    check("ready_full", 32'(dma_ready), 32'h0);
    dma_data = 32'hDEADBEEF;
    tick();
    dma_valid = 1'b0;
    strobe = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      ei = 12'(32'h123 * k);
      check($sformatf("dma_sample%0d", k), 32'(data), 32'({12'hFED, ei}));
      check($sformatf("dma_dunf%0d", k), 32'(dunf), 32'h0);
    end
    tick();
    check("unf_hold", 32'(data), 32'h00FED48C);
    check("unf_valid", 32'(valid_out), 32'h1);
    check("unf_pulse", 32'(dunf), 32'h1);
    check("unf_count1", 32'(dunf_count), 32'h1);
    strobe = 1'b0;
    tick();
    check("unf_pulse_end", 32'(dunf), 32'h0);
    check("no_strobe_valid", 32'(valid_out), 32'h0);
    check("ready_drained", 32'(dma_ready), 32'h1);

    // Push into empty FIFO with a strobe still underflows, then push+pop
    dma_valid = 1'b1; dma_data = {16'h7770, 16'h1110}; strobe = 1'b1;
    tick();
    check("push_empty_unf", 32'(dunf), 32'h1);
    check("push_empty_hold", 32'(data), 32'h00FED48C);
    check("unf_count2", 32'(dunf_count), 32'h2);
    dma_data = {16'hAAA0, 16'h5550};
    tick();
    check("pushpop_a", 32'(data), 32'h00777111);
    check("pushpop_dunf", 32'(dunf), 32'h0);
    dma_valid = 1'b0;
    tick();
    check("pop_b", 32'(data), 32'h00AAA555);
    tick();
    check("unf_after_b", 32'(dunf), 32'h1);
    check("unf_hold_b", 32'(data), 32'h00AAA555);
    check("unf_count3", 32'(dunf_count), 32'h3);
    strobe = 1'b0;
    tick();

    // Ramp full wrap, then restart on reselection
    sel = 2'd2;
    tick();
    strobe = 1'b1;
    for (int i = 0; i <= 4096; i++) begin
      tick();
      r = 12'(i);
      check("ramp", 32'(data), 32'({~r, r}));
    end
    strobe = 1'b0;
    sel = 2'd1;
    tick();
    sel = 2'd2;
    tick();
    strobe = 1'b1;
    tick();
    check("ramp_restart0", 32'(data), 32'h00FFF000);
    tick();
    check("ramp_restart1", 32'(data), 32'h00FFE001);
    strobe = 1'b0;

    // PN15 from reset
    rst = 1'b1; sel = 2'd3;
    tick();
    rst = 1'b0;
    tick();
    strobe = 1'b1;
    l = 15'h7FFF;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("pn%0d", i), 32'(data), 32'({l[14:3], l[11:0]}));
      if (i < 3) check($sformatf("pn_i%0d", i), 32'(data[11:0]), 32'(pn_i[i]));
      l = lfsr_step(l);
    end
    strobe = 1'b0;

    // Underflow counter saturation and clear priority
    sel = 2'd0;
    tick();
    strobe = 1'b1;
    exp_cnt = 16'd0;
    repeat (65535) begin
      tick();
      exp_cnt = exp_cnt + 16'd1;
    end
    check("cnt_reach_max", 32'(dunf_count), 32'(exp_cnt));
    tick();
    check("cnt_saturate", 32'(dunf_count), 32'h0000FFFF);
    check("sat_dunf", 32'(dunf), 32'h1);
    dunf_clr = 1'b1;
    tick();
    check("clr_priority", 32'(dunf_count), 32'h0);
    check("clr_dunf_pulse", 32'(dunf), 32'h1);
    dunf_clr = 1'b0; strobe = 1'b0;
    tick();
    check("clr_stays", 32'(dunf_count), 32'h0);
    check("clr_no_pulse", 32'(dunf), 32'h0);

    // Reset mid-stream with FIFO half full
    sel = 2'd1; pat = 24'h13579B; strobe = 1'b1;
    tick();
    check("pre_rst_data", 32'(data), 32'h0013579B);
    sel = 2'd0; strobe = 1'b0; dma_valid = 1'b1;
    dma_data = 32'h11112222;
    tick();
    dma_data = 32'h33334444;
    tick();
    rst = 1'b1; strobe = 1'b1;
    tick();
    check("midrst_data", 32'(data), 32'h0);
    check("midrst_valid", 32'(valid_out), 32'h0);
    check("midrst_dunf", 32'(dunf), 32'h0);
    check("midrst_ready", 32'(dma_ready), 32'h0);
    rst = 1'b0; dma_valid = 1'b0; strobe = 1'b0;
    tick();
    check("postrst_ready", 32'(dma_ready), 32'h1);
    strobe = 1'b1;
    tick();
    check("postrst_unf", 32'(dunf), 32'h1);
    check("postrst_data", 32'(data), 32'h0);
    check("postrst_count", 32'(dunf_count), 32'h1);
    strobe = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
